// File: rtl/oclib_pkg.sv
// Shared chip-level types.
//   chip_status_s : free-running timebase strobes distributed to every block.
//                   Each tick field may stay high for several clock cycles.
package oclib_pkg;

  typedef struct packed {
    logic tick1s;
    logic tick1ms;
    logic tick1us;
  } chip_status_s;

endpackage

// File: rtl/oc_tick_scheduler.sv
// oc_tick_scheduler
//   Periodic event generator. Each channel counts rising edges of a selected
//   timebase tick (us/ms/s) and fires every cfgPeriod edges. Fired channels are
//   latched as pending and presented one at a time on a valid/ready port,
//   arbitrated round-robin. A fire that lands on an unserved pending event
//   sets a sticky overrun flag.
//
// Ports
//   clock, reset       : single clock, synchronous active-high reset
//   chipStatus         : timebase; tick1us / tick1ms / tick1s are used
//   cfgEnable[ch]      : channel enable
//   cfgUnit[ch]        : 0=us, 1=ms, 2=s, 3=never counts
//   cfgPeriod[ch]      : period in selected ticks (0 disables the channel)
//   cfgClearOverrun[ch]: pulse to clear overrun[ch]
//   eventValid/eventChannel/eventReady : event handshake to the consumer
//   overrun[ch]        : sticky missed-event flags
module oc_tick_scheduler #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned CountWidth  = 16,
  localparam int unsigned ChWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  oclib_pkg::chip_status_s                 chipStatus,
  input  logic [NumChannels-1:0]                  cfgEnable,
  input  logic [NumChannels-1:0][1:0]             cfgUnit,
  input  logic [NumChannels-1:0][CountWidth-1:0]  cfgPeriod,
  input  logic [NumChannels-1:0]                  cfgClearOverrun,
  output logic                                    eventValid,
  output logic [ChWidth-1:0]                      eventChannel,
  input  logic                                    eventReady,
  output logic [NumChannels-1:0]                  overrun
);

  typedef enum logic {
    StIdle,
    StPresent
  } state_e;

  state_e state;
  state_e nextState;

  // tick vector order: [0]=us, [1]=ms, [2]=s
  logic [2:0] tickNow;
  logic [2:0] tickPrev;
  logic [2:0] tickEdge;

  logic [CountWidth-1:0]  counter [NumChannels];
  logic [NumChannels-1:0] pending;
  logic [NumChannels-1:0] chActive;
  logic [NumChannels-1:0] chEdge;
  logic [NumChannels-1:0] chFire;
  logic [NumChannels-1:0] chAccept;

  logic [ChWidth-1:0] lastGrant;
  logic [ChWidth-1:0] nextLastGrant;
  logic [ChWidth-1:0] nextChannel;
  logic               handshake;
  logic               grantFound;

  assign tickNow    = {chipStatus.tick1s, chipStatus.tick1ms, chipStatus.tick1us};
  assign tickEdge   = tickNow & ~tickPrev;
  assign eventValid = (state == StPresent);
  assign handshake  = eventValid && eventReady;

  // Per-channel decode: active, selected edge, fire, and acceptance.
  always_comb begin
    chActive = '0;
    chEdge   = '0;
    chFire   = '0;
    chAccept = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      chActive[i] = cfgEnable[i] && (cfgPeriod[i] != '0);
      case (cfgUnit[i])
        2'd0:    chEdge[i] = tickEdge[0];
        2'd1:    chEdge[i] = tickEdge[1];
        2'd2:    chEdge[i] = tickEdge[2];
        default: chEdge[i] = 1'b0;
      endcase
      // >= rather than == so a period lowered below the running count fires
      // on the next edge instead of wrapping through the full counter range.
      chFire[i]   = chActive[i] && chEdge[i] &&
                    (counter[i] >= (cfgPeriod[i] - CountWidth'(1)));
      chAccept[i] = handshake && (eventChannel == ChWidth'(i));
    end
  end

  // Counters, pending and overrun state.
  always_ff @(posedge clock) begin
    if (reset) begin
      tickPrev <= '0;
      pending  <= '0;
      overrun  <= '0;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        counter[i] <= '0;
      end
    end else begin
      tickPrev <= tickNow;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (!chActive[i]) begin
          counter[i] <= '0;
          pending[i] <= 1'b0;
        end else begin
          if (chEdge[i]) begin
            counter[i] <= chFire[i] ? '0 : counter[i] + CountWidth'(1);
          end
          // A fire coinciding with acceptance re-arms pending without overrun.
          if (chFire[i]) begin
            pending[i] <= 1'b1;
          end else if (chAccept[i]) begin
            pending[i] <= 1'b0;
          end
        end
        // Overrun set outranks a simultaneous clear request.
        if (chFire[i] && pending[i] && !chAccept[i]) begin
          overrun[i] <= 1'b1;
        end else if (cfgClearOverrun[i]) begin
          overrun[i] <= 1'b0;
        end
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      eventChannel <= '0;
      lastGrant    <= ChWidth'(NumChannels - 1);
    end else begin
      state        <= nextState;
      eventChannel <= nextChannel;
      lastGrant    <= nextLastGrant;
    end
  end

  // Next-state logic with round-robin search starting after lastGrant.
  always_comb begin
    int unsigned idx;
    nextState     = state;
    nextChannel   = eventChannel;
    nextLastGrant = lastGrant;
    grantFound    = 1'b0;
    idx           = 0;
    case (state)
      StIdle: begin
        for (int unsigned k = 1; k <= NumChannels; k++) begin
          idx = 32'(lastGrant) + k;
          if (idx >= NumChannels) begin
            idx = idx - NumChannels;
          end
          if (!grantFound && pending[ChWidth'(idx)]) begin
            grantFound  = 1'b1;
            nextChannel = ChWidth'(idx);
          end
        end
        if (grantFound) begin
          nextState = StPresent;
        end
      end
      StPresent: begin
        if (handshake) begin
          nextState     = StIdle;
          nextLastGrant = eventChannel;
        end
      end
      default: nextState = StIdle;
    endcase
  end

endmodule

// File: tb/tb_oc_tick_scheduler.sv
// Directed testbench for oc_tick_scheduler (4 channels, 16-bit counters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_oc_tick_scheduler;

  logic                     clock;
  logic                     reset;
  oclib_pkg::chip_status_s  chipStatus;
  logic [3:0]               cfgEnable;
  logic [3:0][1:0]          cfgUnit;
  logic [3:0][15:0]         cfgPeriod;
  logic [3:0]               cfgClearOverrun;
  logic                     eventValid;
  logic [1:0]               eventChannel;
  logic                     eventReady;
  logic [3:0]               overrun;

  int checks = 0;
  int errors = 0;

  oc_tick_scheduler #(
    .NumChannels(4),
    .CountWidth(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .chipStatus(chipStatus),
    .cfgEnable(cfgEnable),
    .cfgUnit(cfgUnit),
    .cfgPeriod(cfgPeriod),
    .cfgClearOverrun(cfgClearOverrun),
    .eventValid(eventValid),
    .eventChannel(eventChannel),
    .eventReady(eventReady),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // which: 0=us, 1=ms, 2=s, 3=all three
  task automatic setTick(input int which, input logic v);
    if (which == 0 || which == 3) chipStatus.tick1us = v;
    if (which == 1 || which == 3) chipStatus.tick1ms = v;
    if (which == 2 || which == 3) chipStatus.tick1s  = v;
  endtask

  // One tick pulse; counts falling-edge samples with eventValid high.
  task automatic pulse(input int which, input int high, input int low,
                       output int nValid, output int lastCh);
    nValid = 0;
    lastCh = -1;
    setTick(which, 1'b1);
    repeat (high) begin
      @(negedge clock);
      if (eventValid) begin nValid++; lastCh = int'(eventChannel); end
    end
    setTick(which, 1'b0);
    repeat (low) begin
      @(negedge clock);
      if (eventValid) begin nValid++; lastCh = int'(eventChannel); end
    end
  endtask

  task automatic clearCfg();
    cfgEnable       = '0;
    cfgUnit         = '0;
    cfgPeriod       = '0;
    cfgClearOverrun = '0;
    eventReady      = 1'b0;
    setTick(3, 1'b0);
  endtask

  task automatic resetDut();
    clearCfg();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    clearCfg();
    reset = 1'b1;
    step(3);
    checks++;
    if (eventValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d expected 0", eventValid); end
    checks++;
    if (eventChannel !== 2'd0) begin errors++; $display("FAIL reset_channel got %0d expected 0", eventChannel); end
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("FAIL reset_overrun got %h expected 0", overrun); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_basic();
    resetDut();
    cfgEnable[0] = 1'b1; cfgUnit[0] = 2'd0; cfgPeriod[0] = 16'd3; eventReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic expV;
      expV = (k % 3 == 2);
      setTick(0, 1'b1);
      step(1);
      checks++;
      if (eventValid !== 1'b0) begin errors++; $display("FAIL basic_lat1 pulse %0d got %0d expected 0", k, eventValid); end
      setTick(0, 1'b0);
      step(1);
      checks++;
      if (eventValid !== expV) begin errors++; $display("FAIL basic_lat2 pulse %0d got %0d expected %0d", k, eventValid, expV); end
      if (expV) begin
        checks++;
        if (eventChannel !== 2'd0) begin errors++; $display("FAIL basic_channel got %0d expected 0", eventChannel); end
      end
      step(1);
      checks++;
      if (eventValid !== 1'b0) begin errors++; $display("FAIL basic_drop pulse %0d got %0d expected 0", k, eventValid); end
      step(1);
    end
  endtask

  task automatic test_long_tick();
    int nv, ch;
    resetDut();
    cfgEnable[0] = 1'b1; cfgPeriod[0] = 16'd1; eventReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse(0, 5, 3, nv, ch);
      checks++;
      if (nv !== 1) begin errors++; $display("FAIL long_tick_count pulse %0d got %0d expected 1", k, nv); end
    end
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("FAIL long_tick_overrun got %h expected 0", overrun); end
  endtask

  task automatic test_back_to_back();
    int seq[$];
    resetDut();
    cfgEnable = 4'hF;
    for (int i = 0; i < 4; i++) begin cfgUnit[i] = 2'd1; cfgPeriod[i] = 16'd1; end
    eventReady = 1'b1;
    for (int p = 0; p < 2; p++) begin
      seq.delete();
      setTick(1, 1'b1);
      step(1);
      setTick(1, 1'b0);
      for (int c = 0; c < 11; c++) begin
        step(1);
        if (eventValid) seq.push_back(int'(eventChannel));
      end
      checks++;
      if (seq.size() !== 4) begin errors++; $display("FAIL rr_count ms %0d got %0d expected 4", p, seq.size()); end
      for (int i = 0; i < 4 && i < seq.size(); i++) begin
        checks++;
        if (seq[i] !== i) begin errors++; $display("FAIL rr_order ms %0d slot %0d got %0d expected %0d", p, i, seq[i], i); end
      end
    end
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("FAIL rr_overrun got %h expected 0", overrun); end
  endtask

  task automatic test_overrun();
    int nv, ch;
    resetDut();
    cfgEnable[1] = 1'b1; cfgUnit[1] = 2'd0; cfgPeriod[1] = 16'd1;
    pulse(0, 1, 2, nv, ch);
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("FAIL ovr_first got %h expected 0", overrun); end
    pulse(0, 1, 2, nv, ch);
    pulse(0, 1, 2, nv, ch);
    checks++;
    if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_set got %h expected 2", overrun); end
    checks++;
    if (eventValid !== 1'b1 || eventChannel !== 2'd1) begin
      errors++; $display("FAIL ovr_present got valid %0d ch %0d expected valid 1 ch 1", eventValid, eventChannel);
    end
    eventReady = 1'b1;
    step(1);
    checks++;
    if (eventValid !== 1'b0) begin errors++; $display("FAIL ovr_accept got %0d expected 0", eventValid); end
    nv = 0;
    for (int c = 0; c < 6; c++) begin step(1); if (eventValid) nv++; end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL ovr_single_event got %0d extra expected 0", nv); end
    cfgClearOverrun = 4'b0010;
    step(1);
    cfgClearOverrun = '0;
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("FAIL ovr_clear got %h expected 0", overrun); end
    eventReady = 1'b0;
    pulse(0, 1, 2, nv, ch);
    pulse(0, 1, 2, nv, ch);
    checks++;
    if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_reset got %h expected 2", overrun); end
    setTick(0, 1'b1);
    cfgClearOverrun = 4'b0010;
    step(1);
    setTick(0, 1'b0);
    cfgClearOverrun = '0;
    checks++;
    if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_clear_vs_fire got %h expected 2", overrun); end
    step(1);
    eventReady = 1'b1;
    step(3);
    cfgClearOverrun = 4'b0010;
    step(1);
    cfgClearOverrun = '0;
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("FAIL ovr_clear2 got %h expected 0", overrun); end
  endtask

  task automatic test_period_change();
    int nv, ch, total;
    resetDut();
    cfgEnable[2] = 1'b1; cfgUnit[2] = 2'd0; cfgPeriod[2] = 16'd20; eventReady = 1'b1;
    total = 0;
    for (int k = 0; k < 10; k++) begin pulse(0, 1, 3, nv, ch); total += nv; end
    checks++;
    if (total !== 0) begin errors++; $display("FAIL period_before got %0d expected 0", total); end
    cfgPeriod[2] = 16'd5;
    setTick(0, 1'b1);
    step(1);
    setTick(0, 1'b0);
    step(1);
    checks++;
    if (eventValid !== 1'b1 || eventChannel !== 2'd2) begin
      errors++; $display("FAIL period_lower got valid %0d ch %0d expected valid 1 ch 2", eventValid, eventChannel);
    end
    step(2);
    total = 0;
    for (int k = 0; k < 4; k++) begin pulse(0, 1, 3, nv, ch); total += nv; end
    checks++;
    if (total !== 0) begin errors++; $display("FAIL period_restart got %0d expected 0", total); end
    pulse(0, 1, 3, nv, ch);
    checks++;
    if (nv !== 1 || ch !== 2) begin errors++; $display("FAIL period_fifth got count %0d ch %0d expected 1 ch 2", nv, ch); end
  endtask

  task automatic test_unit_never();
    int nv, ch, total;
    resetDut();
    cfgEnable[0] = 1'b1; cfgUnit[0] = 2'd3; cfgPeriod[0] = 16'd1; eventReady = 1'b1;
    total = 0;
    for (int k = 0; k < 3; k++) begin pulse(3, 1, 3, nv, ch); total += nv; end
    checks++;
    if (total !== 0) begin errors++; $display("FAIL unit3_events got %0d expected 0", total); end
    cfgUnit[0] = 2'd2;
    pulse(2, 1, 3, nv, ch);
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL unit_s_event got %0d expected 1", nv); end
  endtask

  task automatic test_disable_presented();
    int nv, ch, total;
    resetDut();
    cfgEnable[0] = 1'b1; cfgPeriod[0] = 16'd1;
    pulse(0, 1, 2, nv, ch);
    cfgEnable[0] = 1'b0;
    step(3);
    checks++;
    if (eventValid !== 1'b1 || eventChannel !== 2'd0) begin
      errors++; $display("FAIL disable_hold got valid %0d ch %0d expected valid 1 ch 0", eventValid, eventChannel);
    end
    eventReady = 1'b1;
    step(1);
    checks++;
    if (eventValid !== 1'b0) begin errors++; $display("FAIL disable_complete got %0d expected 0", eventValid); end
    total = 0;
    for (int k = 0; k < 3; k++) begin pulse(0, 1, 3, nv, ch); total += nv; end
    checks++;
    if (total !== 0) begin errors++; $display("FAIL disable_no_more got %0d expected 0", total); end
  endtask

  task automatic test_reset_mid();
    int nv, ch;
    resetDut();
    cfgEnable = 4'b0011; cfgPeriod[0] = 16'd1; cfgPeriod[1] = 16'd1;
    pulse(0, 1, 2, nv, ch);
    checks++;
    if (eventValid !== 1'b1) begin errors++; $display("FAIL rstmid_present got %0d expected 1", eventValid); end
    eventReady = 1'b1;
    reset = 1'b1;
    step(1);
    checks++;
    if (eventValid !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %0d expected 0", eventValid); end
    reset = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin step(1); if (eventValid) nv++; end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL rstmid_discard got %0d expected 0", nv); end
  endtask

  initial begin
    reset = 1'b1;
    clearCfg();
    test_reset();
    test_basic();
    test_long_tick();
    test_back_to_back();
    test_overrun();
    test_period_change();
    test_unit_never();
    test_disable_presented();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oc_tick_scheduler.md
OC_TICK_SCHEDULER -- requirements
Module: oc_tick_scheduler

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of independent periodic channels (1..16).
REQ-002 SHALL have parameter CountWidth, default 16, width of per-channel period and counter.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port chipStatus  input  oclib_pkg::chip_status_s  timebase; only tick1us, tick1ms and tick1s are used.
REQ-006 SHALL have port cfgEnable  input  NumChannels  per-channel enable.
REQ-007 SHALL have port cfgUnit  input  NumChannels x 2  per-channel tick select: 0=us, 1=ms, 2=s, 3=never counts.
REQ-008 SHALL have port cfgPeriod  input  NumChannels x CountWidth  per-channel period, in selected ticks.
REQ-009 SHALL have port cfgClearOverrun  input  NumChannels  one-cycle pulse; clears matching overrun bit.
REQ-010 SHALL have port eventValid  output  1  event presented to consumer.
REQ-011 SHALL have port eventChannel  output  $clog2(NumChannels) (min 1)  channel index of presented event.
REQ-012 SHALL have port eventReady  input  1  consumer accepts; handshake completes when eventValid && eventReady.
REQ-013 SHALL have port overrun  output  NumChannels  sticky per-channel missed-event flags.

Function
REQ-014 SHALL register each tick field once and form edge = tick & ~tickPrev; tick fields may stay high several cycles and SHALL count exactly once per rising edge.
REQ-015 SHALL hold a channel's counter at 0 and its pending bit at 0 while its cfgEnable=0, or while cfgPeriod=0.
REQ-016 SHALL, for an enabled channel with period P>0, increment its counter on each edge of its selected unit; when the edge arrives with counter >= P-1, counter SHALL load 0 and the channel SHALL "fire".
REQ-017 SHALL use the >= compare so that lowering cfgPeriod below the current count fires on the next edge, with no wrap through 2^CountWidth.
REQ-018 SHALL set the channel's pending bit on fire; it is visible the cycle after the edge.
REQ-019 SHALL, when a fire occurs while pending is already set and that channel is not being accepted the same cycle, leave pending set and set overrun[ch].
REQ-020 SHALL, when fire and acceptance of the same channel coincide, leave pending set and SHALL NOT set overrun.
REQ-021 SHALL give cfgClearOverrun lower priority than a simultaneous overrun set, so the bit remains 1.
REQ-022 SHALL have a two-state output FSM: IDLE (eventValid=0) and PRESENT (eventValid=1).
REQ-023 SHALL, in IDLE with any pending bit set, select one channel round-robin starting at lastGrant+1 (mod NumChannels), register it into eventChannel and move to PRESENT; latency is tick edge to eventValid = 2 cycles.
REQ-024 SHALL hold eventChannel stable while in PRESENT and eventReady=0.
REQ-025 SHALL, on handshake, clear that channel's pending bit (except REQ-020), update lastGrant and return to IDLE; maximum throughput is one event per 2 cycles.
REQ-026 SHALL NOT retract a presented event when its channel is disabled; the event SHALL complete on handshake, and only pending and counter state SHALL be cleared.
REQ-027 SHALL treat cfgUnit=3 as no tick; the counter holds its value.

Reset
REQ-028 SHALL, on reset, clear eventValid, eventChannel, overrun, all counters, all pending bits and tickPrev, set lastGrant=NumChannels-1 (channel 0 highest priority), and enter IDLE.
REQ-029 SHALL, on reset asserted mid-handshake, drop eventValid the next cycle and discard all pending events.
REQ-030 SHALL ignore tick edges during reset; the first edge after reset deasserts counts only if tickPrev was 0.

Verification
REQ-031 SHALL verify: ch0 enabled, unit=us, P=3, eventReady=1 -> eventValid every 3rd tick1us edge, 2 cycles after the edge, with eventChannel=0.
REQ-032 SHALL verify: tick1us held high 5 cycles per pulse, P=1 -> exactly one event per pulse.
REQ-033 SHALL verify: ch0..ch3 all P=1 unit=ms, eventReady=1 -> events in order 0,1,2,3 per ms; no overrun.
REQ-034 SHALL verify: ch1 P=1 unit=us, eventReady=0 for 3 us -> single pending event, overrun[1]=1; a cfgClearOverrun[1] pulse clears it only when no simultaneous fire occurs.
REQ-035 SHALL verify: ch2 counter=10 with P=20, then cfgPeriod changed to 5 -> fire on the next edge, counter=0.
REQ-036 SHALL verify: event presented for ch0, then cfgEnable[0]=0 -> eventValid stays 1 until eventReady, after which no further ch0 events occur.
